audio_mix: RTL and testbench

- Downstream stage of the sound subsystem. Consumes the YM2151 stereo output (AUDIO_L/AUDIO_R) and the 8-bit sample DAC written by the sound CPU.
- Removes DC from the DAC, applies per-source gain, and produces a saturated stereo sum.
- An optional one-pole low-pass filter follows the sum. The output feeds the top-level audio path.
- One shared multiplier, time-multiplexed by a small FSM, once per sample strobe.

---
 rtl/audio_pkg.sv | 39 +++
 rtl/audio_mix_if.sv | 34 +++
 rtl/audio_onepole.sv | 42 ++++
 rtl/audio_mix.sv | 158 +++++++++++++++
 tb/tb_audio_mix.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared types, constants and saturation helper for the audio mixer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic        [7:0]  gain_t;

  localparam int SAT_MAX  = 32767;
  localparam int SAT_MIN  = -32768;
  localparam int DC_SHIFT = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DCB    = 3'd1,
    MIX_L  = 3'd2,
    MIX_R  = 3'd3,
    FILT_L = 3'd4,
    FILT_R = 3'd5,
    OUT    = 3'd6
  } mix_state_t;

  function automatic sample_t sat16(input logic signed [17:0] v);
    if (v > SAT_MAX) begin
      return 16'sh7fff;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_mix_if.sv
// ============================================================================
// Module   : audio_mix_if
// Purpose  : Sample-strobe, source and mixed-output bundle of the audio mixer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface audio_mix_if;
  import audio_pkg::*;

  logic       CE_SAMPLE;
  sample_t    YM_L;
  sample_t    YM_R;
  logic       DAC_WR;
  logic [7:0] DAC_DIN;
  logic       FILTER_EN;
  logic       pause;
  sample_t    AUDIO_L;
  sample_t    AUDIO_R;
  logic       AUDIO_VALID;

  modport master (
    output CE_SAMPLE, YM_L, YM_R, DAC_WR, DAC_DIN, FILTER_EN, pause,
    input  AUDIO_L, AUDIO_R, AUDIO_VALID
  );

  modport slave (
    input  CE_SAMPLE, YM_L, YM_R, DAC_WR, DAC_DIN, FILTER_EN, pause,
    output AUDIO_L, AUDIO_R, AUDIO_VALID
  );

endinterface

`default_nettype wire

// File: rtl/audio_onepole.sv
// ============================================================================
// Module   : audio_onepole
// Purpose  : One channel of the optional one-pole low-pass (or bypass) stage
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_onepole
  import audio_pkg::*;
#(
  parameter int LPF_SHIFT = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  input  wire logic    update,
  input  wire logic    filter_en,
  input  wire sample_t m,
  output sample_t      y
);

  logic signed [17:0] m_x;
  logic signed [17:0] y_x;
  logic signed [17:0] diff;
  logic signed [17:0] sum;

  assign m_x  = {{2{m[15]}}, m};
  assign y_x  = {{2{y[15]}}, y};
  assign diff = m_x - y_x;
  assign sum  = y_x + (diff >>> LPF_SHIFT);

  // State only moves on the update strobe, so it stays frozen between samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else if (update) begin
      y <= filter_en ? sat16(sum) : m;
    end
  end

endmodule

`default_nettype wire

// File: rtl/audio_mix.sv
// ============================================================================
// Module   : audio_mix
// Purpose  : DC-blocked DAC + FM stereo mixer with saturation and optional LPF
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_mix
  import audio_pkg::*;
#(
  parameter gain_t YM_GAIN   = 8'd128,
  parameter gain_t DAC_GAIN  = 8'd96,
  parameter int    LPF_SHIFT = 2
) (
  input  wire logic  CLK_32M,
  input  wire logic  RESET,
  audio_mix_if.slave bus
);

  mix_state_t         state;
  logic [7:0]         dac_reg;
  logic [7:0]         snap_dac;
  sample_t            snap_l;
  sample_t            snap_r;
  logic signed [25:0] dc_est;
  logic signed [17:0] dac_term;
  sample_t            m_l;
  sample_t            m_r;
  sample_t            y_l;
  sample_t            y_r;
  sample_t            out_l;
  sample_t            out_r;
  logic               out_valid;

  logic signed [8:0]  dac_x;
  sample_t            dac_s;
  logic signed [25:0] e_shr;
  logic signed [17:0] s18;
  logic signed [17:0] e18;
  sample_t            dac_ac;
  logic signed [26:0] e_err;
  logic signed [26:0] e_step;
  logic signed [25:0] dc_next;

  assign dac_x   = $signed({1'b0, snap_dac}) - 9'sd128;
  assign dac_s   = {dac_x[7:0], 8'd0};
  assign e_shr   = dc_est >>> DC_SHIFT;
  assign s18     = {{2{dac_s[15]}}, dac_s};
  assign e18     = e_shr[17:0];
  assign dac_ac  = sat16(s18 - e18);
  assign e_err   = {dac_s[15], dac_s, 10'd0} - {dc_est[25], dc_est};
  assign e_step  = e_err >>> DC_SHIFT;
  assign dc_next = dc_est + e_step[25:0];

  // Single multiplier: DAC gain in DCB, FM gain for the matching channel in MIX_L/MIX_R.
  sample_t            mul_a;
  logic signed [8:0]  mul_b;
  logic signed [24:0] mul_p;
  logic signed [17:0] prod_scaled;

  always_comb begin
    mul_a = dac_ac;
    mul_b = {1'b0, DAC_GAIN};
    case (state)
      MIX_L: begin
        mul_a = snap_l;
        mul_b = {1'b0, YM_GAIN};
      end
      MIX_R: begin
        mul_a = snap_r;
        mul_b = {1'b0, YM_GAIN};
      end
      default: ;
    endcase
  end

  assign mul_p       = 25'(mul_a) * 25'(mul_b);
  assign prod_scaled = mul_p[24:7];

  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      state     <= IDLE;
      dac_reg   <= 8'h80;
      snap_dac  <= 8'h80;
      snap_l    <= '0;
      snap_r    <= '0;
      dc_est    <= '0;
      dac_term  <= '0;
      m_l       <= '0;
      m_r       <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (bus.DAC_WR) begin
        dac_reg <= bus.DAC_DIN;
      end
      case (state)
        IDLE: begin
          if (bus.CE_SAMPLE && !bus.pause) begin
            snap_l   <= bus.YM_L;
            snap_r   <= bus.YM_R;
            snap_dac <= dac_reg;
            state    <= DCB;
          end
        end
        DCB: begin
          dc_est   <= dc_next;
          dac_term <= prod_scaled;
          state    <= MIX_L;
        end
        MIX_L: begin
          m_l   <= sat16(prod_scaled + dac_term);
          state <= MIX_R;
        end
        MIX_R: begin
          m_r   <= sat16(prod_scaled + dac_term);
          state <= FILT_L;
        end
        FILT_L: state <= FILT_R;
        FILT_R: state <= OUT;
        OUT: begin
          out_l     <= y_l;
          out_r     <= y_r;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  audio_onepole #(.LPF_SHIFT(LPF_SHIFT)) u_lpf_l (
    .clk       (CLK_32M),
    .rst       (RESET),
    .update    (state == FILT_L),
    .filter_en (bus.FILTER_EN),
    .m         (m_l),
    .y         (y_l)
  );

  audio_onepole #(.LPF_SHIFT(LPF_SHIFT)) u_lpf_r (
    .clk       (CLK_32M),
    .rst       (RESET),
    .update    (state == FILT_R),
    .filter_en (bus.FILTER_EN),
    .m         (m_r),
    .y         (y_r)
  );

  assign bus.AUDIO_L     = out_l;
  assign bus.AUDIO_R     = out_r;
  assign bus.AUDIO_VALID = out_valid;

endmodule

`default_nettype wire

// File: tb/tb_audio_mix.sv
// ============================================================================
// Module   : tb_audio_mix
// Purpose  : Scoreboard bench for audio_mix against an integer reference model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_audio_mix;
  import audio_pkg::*;

  localparam int YG = 128;
  localparam int DG = 128;
  localparam int SH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rst_seen = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  audio_mix_if bus();

  audio_mix #(.YM_GAIN(8'd128), .DAC_GAIN(8'd128), .LPF_SHIFT(SH)) dut (
    .CLK_32M (clk),
    .RESET   (rst),
    .bus     (bus.slave)
  );

  typedef struct {int l; int r; int due;} exp_t;
  exp_t   q[$];
  int     m_dac;
  longint m_e;
  int     m_yl, m_yr;
  int     next_free;
  int     last_l, last_r;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint floor_pow2(input longint a, input int k);
    longint d = longint'(1) << k;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference: one output sample computed straight from the arithmetic rules.
  task automatic model_sample(input int yl, input int yr);
    longint s, ac, ml, mr;
    s   = longint'(m_dac - 128) * 256;
    ac  = sat(s - floor_pow2(m_e, 10));
    m_e = m_e + floor_pow2(s * 1024 - m_e, 10);
    ml  = sat(floor_pow2(longint'(yl) * YG, 7) + floor_pow2(ac * DG, 7));
    mr  = sat(floor_pow2(longint'(yr) * YG, 7) + floor_pow2(ac * DG, 7));
    if (bus.FILTER_EN) begin
      m_yl = sat(m_yl + floor_pow2(ml - m_yl, SH));
      m_yr = sat(m_yr + floor_pow2(mr - m_yr, SH));
    end else begin
      m_yl = int'(ml);
      m_yr = int'(mr);
    end
    q.push_back('{m_yl, m_yr, cyc + 7});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      if (bus.DAC_WR) m_dac = int'(bus.DAC_DIN);
      @(posedge clk);
      #1;
      bus.CE_SAMPLE = 1'b0;
      bus.DAC_WR    = 1'b0;
    end
  endtask

  task automatic dac_write(input int v);
    bus.DAC_WR  = 1'b1;
    bus.DAC_DIN = 8'(v);
  endtask

  // Strobe a sample; the model only accepts it when the mixer would be idle.
  task automatic sample(input int yl, input int yr);
    bus.YM_L      = 16'(yl);
    bus.YM_R      = 16'(yr);
    bus.CE_SAMPLE = 1'b1;
    if (!bus.pause && cyc >= next_free) begin
      model_sample(yl, yr);
      next_free = cyc + 7;
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.CE_SAMPLE = 1'b0;
    bus.DAC_WR    = 1'b0;
    tick(2);
    rst       = 1'b0;
    q.delete();
    m_dac     = 128;
    m_e       = 0;
    m_yl      = 0;
    m_yr      = 0;
    next_free = 0;
  endtask

  always @(negedge clk) begin
    if (rst_seen) begin
      check("rst_valid", int'(bus.AUDIO_VALID), 0);
      check("rst_l", int'(bus.AUDIO_L), 0);
      check("rst_r", int'(bus.AUDIO_R), 0);
      last_l = 0;
      last_r = 0;
    end else if (bus.AUDIO_VALID) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency", cyc, e.due);
        check("out_l", int'(bus.AUDIO_L), e.l);
        check("out_r", int'(bus.AUDIO_R), e.r);
        last_l = e.l;
        last_r = e.r;
      end
    end else begin
      check("hold_l", int'(bus.AUDIO_L), last_l);
      check("hold_r", int'(bus.AUDIO_R), last_r);
      if (q.size() > 0 && cyc > q[0].due) begin
        check("missing_valid", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev;
    bus.CE_SAMPLE = 1'b0;
    bus.YM_L      = '0;
    bus.YM_R      = '0;
    bus.DAC_WR    = 1'b0;
    bus.DAC_DIN   = 8'h80;
    bus.FILTER_EN = 1'b0;
    bus.pause     = 1'b0;
    do_reset();

    // Plain FM pass-through with the DAC at midscale.
    sample(16'h1000, -4096);
    tick(8);
    check("t1_l", int'(bus.AUDIO_L), 4096);
    check("t1_r", int'(bus.AUDIO_R), -4096);

    // Positive and negative saturation.
    do_reset();
    dac_write(8'hFF);
    tick(1);
    sample(16'h7000, 0);
    tick(8);
    check("t2_pos_sat", int'(bus.AUDIO_L), 32767);
    dac_write(8'h00);
    tick(1);
    sample(-28672, 0);
    tick(8);
    check("t2_neg_sat", int'(bus.AUDIO_L), -32768);

    // DC blocker decay on a held full-scale DAC.
    do_reset();
    dac_write(8'hFF);
    tick(1);
    prev = 32767;
    for (int i = 0; i < 760; i++) begin
      sample(0, 0);
      tick(7);
      if (i == 0) check("t3_first", int'(bus.AUDIO_L), 32512);
      check("t3_monotonic", int'(int'(bus.AUDIO_L) <= prev), 1);
      prev = int'(bus.AUDIO_L);
    end
    check("t3_below_half", int'(prev < 16384), 1);

    // Low-pass step response.
    do_reset();
    bus.FILTER_EN = 1'b1;
    sample(16'h4000, 0); tick(8);
    check("t4_s1", int'(bus.AUDIO_L), 16'h1000);
    sample(16'h4000, 0); tick(8);
    check("t4_s2", int'(bus.AUDIO_L), 16'h1C00);
    sample(16'h4000, 0); tick(8);
    check("t4_s3", int'(bus.AUDIO_L), 16'h2500);

    // Pause: strobes ignored, state frozen, then resumes where it left off.
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample(16'h4000, 0);
      tick(8);
    end
    check("t5_hold", int'(bus.AUDIO_L), 16'h2500);
    bus.pause = 1'b0;
    sample(16'h4000, 0); tick(8);
    check("t5_resume", int'(bus.AUDIO_L), 16'h2BC0);
    sample(16'h2000, 16'h1234); tick(1);
    bus.pause = 1'b1;
    tick(7);
    bus.pause = 1'b0;

    // Reset in FILT_L aborts the sequence.
    bus.FILTER_EN = 1'b0;
    sample(16'h3000, 16'h3000);
    tick(4);
    do_reset();
    tick(8);
    check("t6_abort_l", int'(bus.AUDIO_L), 0);

    // DAC write coincident with the strobe: snapshot sees the old value.
    dac_write(8'hFF);
    sample(0, 0);
    tick(8);
    check("t6_old_dac", int'(bus.AUDIO_L), 0);
    sample(0, 0);
    tick(8);
    check("t6_new_dac", int'(bus.AUDIO_L), 32512);

    // Randomised traffic.
    for (int it = 0; it < 200; it++) begin
      int gap;
      bus.FILTER_EN = 1'($urandom);
      bus.pause     = ($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) dac_write(int'($urandom_range(255)));
      sample(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
      gap = int'($urandom_range(10, 7));
      for (int k = 1; k < gap; k++) begin
        tick(1);
        if ($urandom_range(5) == 0) dac_write(int'($urandom_range(255)));
        if (k < 6 && $urandom_range(9) == 0)
          sample(int'($urandom_range(65535)) - 32768, 0);
      end
      tick(1);
    end
    bus.pause = 1'b0;
    tick(12);
    check("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
